lcd_pic_writer: RTL and testbench

- Downstream consumer of the picture ROMs (9-bit words {data[7:0], rs}).
- Sequences one ROM image out to the graphic LCD over an 8080-style write-only parallel bus: restarts the ROM, strobes each word onto the bus with programmable WR timing, then steps the ROM one word forward.
- Sits between the game/scene controller (start/done) and the LCD pins; one instance is shared by the picture ROMs through an external mux.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_wr_strobe.sv | 74 +++++++
 rtl/lcd_pic_writer.sv | 107 ++++++++++
 tb/tb_lcd_pic_writer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the picture-ROM to LCD writer: FSM encodings and ROM word layout.
package lcd_pkg;

  localparam int unsigned ROM_LEN_W = 10;
  localparam int unsigned ROM_W     = 9;
  localparam int unsigned RS_BIT    = 0;
  localparam int unsigned DB_MSB    = 8;
  localparam int unsigned DB_LSB    = 1;
  localparam int unsigned DB_W      = DB_MSB - DB_LSB + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    LOAD  = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    ADV   = 3'd5,
    DONE  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_LO   = 2'd1,
    PH_HI   = 2'd2
  } wr_phase_e;

endpackage

// File: rtl/lcd_wr_strobe.sv
// WR strobe generator: on go, drives wr_n low for WR_LOW cycles then high for WR_HIGH cycles.
// The *_last_c flags mark the final cycle of each phase so the caller can step in lockstep.
module lcd_wr_strobe
  import lcd_pkg::*;
#(
  parameter int unsigned WR_LOW  = 2,
  parameter int unsigned WR_HIGH = 2,
  parameter int unsigned TW      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic wr_n,
  output logic lo_last_c,
  output logic hi_last_c
);

  localparam logic [TW-1:0] LO_END = TW'(WR_LOW - 1);
  localparam logic [TW-1:0] HI_END = TW'(WR_HIGH - 1);

  wr_phase_e       ph_q, ph_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            wr_n_d;

  assign lo_last_c = (ph_q == PH_LO) && (tmr_q == LO_END);
  assign hi_last_c = (ph_q == PH_HI) && (tmr_q == HI_END);

  // Timer restarts from zero on every phase entry
  always_comb begin
    ph_d   = ph_q;
    tmr_d  = tmr_q + TW'(1);
    wr_n_d = 1'b1;
    case (ph_q)
      PH_IDLE: begin
        tmr_d = '0;
        if (go) begin
          ph_d   = PH_LO;
          wr_n_d = 1'b0;
        end
      end
      PH_LO: begin
        if (lo_last_c) begin
          ph_d  = PH_HI;
          tmr_d = '0;
        end else begin
          wr_n_d = 1'b0;
        end
      end
      PH_HI: begin
        if (hi_last_c) begin
          ph_d  = PH_IDLE;
          tmr_d = '0;
        end
      end
      default: begin
        ph_d  = PH_IDLE;
        tmr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q  <= PH_IDLE;
      tmr_q <= '0;
      wr_n  <= 1'b1;
    end else begin
      ph_q  <= ph_d;
      tmr_q <= tmr_d;
      wr_n  <= wr_n_d;
    end
  end

endmodule

// File: rtl/lcd_pic_writer.sv
// Streams one picture ROM image onto an 8080-style write-only LCD bus.
// Outputs are registered from the state being entered, so they line up with the FSM state.
module lcd_pic_writer
  import lcd_pkg::*;
#(
  parameter int unsigned WR_LOW  = 2,
  parameter int unsigned WR_HIGH = 2,
  parameter int unsigned TW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [ROM_W-1:0]     rom_d_i,
  input  logic [ROM_LEN_W-1:0] rom_length_i,
  output logic                 rom_sync_o,
  output logic                 rom_en_o,
  output logic                 lcd_cs_n_o,
  output logic                 lcd_rs_o,
  output logic                 lcd_wr_n_o,
  output logic [DB_W-1:0]      lcd_db_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ROM_LEN_W-1:0] word_cnt_o
);

  state_e               state_q, state_d;
  logic [ROM_LEN_W-1:0] len_q, len_d, word_cnt_d;
  logic [DB_W-1:0]      db_d;
  logic                 rs_d, sync_d, en_d, cs_n_d, busy_d, done_d;
  logic                 strobe_go_c, lo_last_c, hi_last_c;

  assign strobe_go_c = (state_q == LOAD);

  lcd_wr_strobe #(
    .WR_LOW (WR_LOW),
    .WR_HIGH(WR_HIGH),
    .TW     (TW)
  ) u_wr_strobe (
    .clk      (clk),
    .rst      (rst),
    .go       (strobe_go_c),
    .wr_n     (lcd_wr_n_o),
    .lo_last_c(lo_last_c),
    .hi_last_c(hi_last_c)
  );

  // Next state, latched length and bus payload
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_o;
    db_d       = lcd_db_o;
    rs_d       = lcd_rs_o;
    case (state_q)
      IDLE:    if (start_i) state_d = SYNC;
      SYNC: begin
        len_d   = rom_length_i;
        state_d = LOAD;
      end
      LOAD: begin
        db_d    = rom_d_i[DB_MSB:DB_LSB];
        rs_d    = rom_d_i[RS_BIT];
        state_d = WR_LO;
      end
      WR_LO:   if (lo_last_c) state_d = WR_HI;
      WR_HI:   if (hi_last_c) state_d = (word_cnt_o == len_q) ? DONE : ADV;
      ADV:     state_d = LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sync_d = (state_d == SYNC);
    en_d   = (state_d != ADV);
    cs_n_d = (state_d == IDLE) || (state_d == DONE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    if (state_d == SYNC)     word_cnt_d = '0;
    else if (state_d == ADV) word_cnt_d = word_cnt_o + ROM_LEN_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      rom_sync_o <= 1'b0;
      rom_en_o   <= 1'b1;
      lcd_cs_n_o <= 1'b1;
      lcd_rs_o   <= 1'b0;
      lcd_db_o   <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      word_cnt_o <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rom_sync_o <= sync_d;
      rom_en_o   <= en_d;
      lcd_cs_n_o <= cs_n_d;
      lcd_rs_o   <= rs_d;
      lcd_db_o   <= db_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      word_cnt_o <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_lcd_pic_writer.sv
// Bench for lcd_pic_writer: frame-timeline model checked every cycle on two parameterisations,
// plus directed frame-level checks against hand-computed counts.
module tb_lcd_pic_writer;

  typedef struct packed {
    logic       rom_sync;
    logic       rom_en;
    logic       cs_n;
    logic       wr_n;
    logic       busy;
    logic       done;
    logic       rs;
    logic [7:0] db;
    logic [9:0] wc;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start2;
  logic [9:0] len1, len2;
  logic [8:0] rom_mem [64];
  logic [5:0] rc1 = '0, rc2 = '0;
  logic [8:0] rd1, rd2;

  logic       sync1, en1, cs1, rs1, wr1, busy1, done1;
  logic [7:0] db1;
  logic [9:0] wc1;
  logic       sync2, en2, cs2, rs2, wr2, busy2, done2;
  logic [7:0] db2;
  logic [9:0] wc2;
  obs_t       a1, a2;

  assign rd1 = rom_mem[rc1];
  assign rd2 = rom_mem[rc2];
  assign a1  = {sync1, en1, cs1, wr1, busy1, done1, rs1, db1, wc1};
  assign a2  = {sync2, en2, cs2, wr2, busy2, done2, rs2, db2, wc2};

  lcd_pic_writer #(.WR_LOW(2), .WR_HIGH(2), .TW(4)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .rom_d_i(rd1), .rom_length_i(len1),
    .rom_sync_o(sync1), .rom_en_o(en1), .lcd_cs_n_o(cs1), .lcd_rs_o(rs1),
    .lcd_wr_n_o(wr1), .lcd_db_o(db1), .busy_o(busy1), .done_o(done1), .word_cnt_o(wc1)
  );

  lcd_pic_writer #(.WR_LOW(3), .WR_HIGH(1), .TW(4)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .rom_d_i(rd2), .rom_length_i(len2),
    .rom_sync_o(sync2), .rom_en_o(en2), .lcd_cs_n_o(cs2), .lcd_rs_o(rs2),
    .lcd_wr_n_o(wr2), .lcd_db_o(db2), .busy_o(busy2), .done_o(done2), .word_cnt_o(wc2)
  );

  // ROM address counters: sync clears, a low rom_en steps by one
  always @(posedge clk) begin
    if (sync1) rc1 <= '0; else if (!en1) rc1 <= rc1 + 6'd1;
    if (sync2) rc2 <= '0; else if (!en2) rc2 <= rc2 + 6'd1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s @%0t got=%0d want=%0d", nm, $time, got, want);
    end
  endtask

  task automatic cmp(input string nm, input obs_t a, input obs_t e, input obs_t m);
    checks++;
    if ((a & m) !== (e & m)) begin
      errors++;
      $display("FAIL %s @%0t got=%h want=%h", nm, $time, a & m, e & m);
    end
  endtask

  function automatic int flen(input int n, input int lw, input int hw);
    return n * (2 + lw + hw) + 1;
  endfunction

  // Expected outputs at cycle k of a frame (k=0 idle, k=1 first busy cycle)
  function automatic void model(input int k, input int n, input int lw, input int hw,
                                output obs_t e, output obs_t m);
    int per, j, w, o;
    e = '{rom_sync:1'b0, rom_en:1'b1, cs_n:1'b1, wr_n:1'b1, busy:1'b0, done:1'b0,
          rs:1'b0, db:8'h00, wc:10'd0};
    m = '1;
    m.db = '0; m.rs = 1'b0; m.wc = '0;
    if (k == 1) begin
      e.rom_sync = 1'b1; e.cs_n = 1'b0; e.busy = 1'b1; m.wc = '1;
    end else if (k >= 2) begin
      per = 2 + lw + hw;
      j = k - 2; w = j / per; o = j % per;
      e.cs_n = 1'b0; e.busy = 1'b1; e.wc = 10'(w); m.wc = '1;
      if (o >= 1 && o <= lw) e.wr_n = 1'b0;
      if (o >= 1) begin
        e.db = rom_mem[w][8:1]; e.rs = rom_mem[w][0]; m.db = '1; m.rs = 1'b1;
      end
      if (o == per - 1) begin
        if (w == n - 1) begin
          e.done = 1'b1; e.cs_n = 1'b1;
        end else begin
          e.rom_en = 1'b0; e.wc = 10'(w + 1);
        end
      end
    end
  endfunction

  int         k1 = 0, n1 = 1, k2 = 0, n2 = 1;
  int         strobes1 = 0, enlow1 = 0, syncs1 = 0, dones1 = 0, bcyc1 = 0, done_at1 = 0;
  int         strobes2 = 0, dones2 = 0, bcyc2 = 0, done_at2 = 0, lorun2 = 0;
  logic       prev_wr1 = 1'b1, prev_wr2 = 1'b1;
  logic [8:0] first_w1 = '0, last_w1 = '0;

  // Per-cycle compare against the model, plus frame statistics
  initial begin
    obs_t e, m;
    forever begin
      @(negedge clk);
      if (rst) begin
        e = '{rom_sync:1'b0, rom_en:1'b1, cs_n:1'b1, wr_n:1'b1, busy:1'b0, done:1'b0,
              rs:1'b0, db:8'h00, wc:10'd0};
        m = '1;
        cmp("dut1_reset", a1, e, m);
        cmp("dut2_reset", a2, e, m);
        k1 = 0; k2 = 0;
      end else begin
        model(k1, n1, 2, 2, e, m);
        cmp("dut1_cycle", a1, e, m);
        if (k1 == 0) begin
          if (start1) k1 = 1;
        end else begin
          if (k1 == 1) n1 = int'(len1) + 1;
          k1 = (k1 == flen(n1, 2, 2)) ? 0 : k1 + 1;
        end
        model(k2, n2, 3, 1, e, m);
        cmp("dut2_cycle", a2, e, m);
        if (k2 == 0) begin
          if (start2) k2 = 1;
        end else begin
          if (k2 == 1) n2 = int'(len2) + 1;
          k2 = (k2 == flen(n2, 3, 1)) ? 0 : k2 + 1;
        end
      end
      if (sync1) syncs1++;
      if (!en1) enlow1++;
      if (wr1 && !prev_wr1) begin
        strobes1++;
        last_w1 = {db1, rs1};
        if (wc1 == 10'd0) first_w1 = {db1, rs1};
      end
      prev_wr1 = wr1;
      if (busy1) bcyc1++; else bcyc1 = 0;
      if (done1) begin dones1++; done_at1 = bcyc1; end
      if (!wr2) lorun2++;
      else if (!prev_wr2) begin
        strobes2++;
        chk("dut2_wr_low_run", lorun2, 3);
        lorun2 = 0;
      end
      prev_wr2 = wr2;
      if (busy2) bcyc2++; else bcyc2 = 0;
      if (done2) begin dones2++; done_at2 = bcyc2; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse1();
    start1 = 1'b1; tick(1); start1 = 1'b0;
  endtask

  task automatic wait_done1(input string nm, input int lim);
    int d0;
    bit seen;
    d0 = dones1; seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      tick(1);
      if (dones1 != d0) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout @%0t got=no_done want=done", nm, $time);
    end
  endtask

  task automatic wait_wc1(input string nm, input int w, input bit need_low, input int lim);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      tick(1);
      if (int'(wc1) == w && (!need_low || !wr1)) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout @%0t got=no_word want=word%0d", nm, $time, w);
    end
  endtask

  initial begin
    int s0, e0, y0, d0, t2;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; len1 = 10'd50; len2 = 10'd3;
    for (int i = 0; i < 64; i++) rom_mem[i] = {8'(i * 37 + 11), 1'b1};
    rom_mem[0] = {8'h3e, 1'b0}; rom_mem[1] = {8'hbd, 1'b0};
    rom_mem[2] = {8'h6e, 1'b0}; rom_mem[3] = {8'h03, 1'b1};
    rom_mem[50] = {8'h3f, 1'b0};
    tick(2);
    rst = 1'b0;
    tick(2);

    // 51-word frame with a second start and a length change mid-frame
    s0 = strobes1; e0 = enlow1; y0 = syncs1; d0 = dones1;
    pulse1();
    wait_wc1("A_word10", 10, 1'b0, 200);
    len1 = 10'd5;
    pulse1();
    wait_done1("A", 400);
    tick(10);
    chk("A_done_cycle", done_at1, 307);
    chk("A_strobes", strobes1 - s0, 51);
    chk("A_en_low", enlow1 - e0, 50);
    chk("A_syncs", syncs1 - y0, 1);
    chk("A_dones", dones1 - d0, 1);
    chk("A_first_word", int'(first_w1), int'({8'h3e, 1'b0}));
    chk("A_last_word", int'(last_w1), int'({8'h3f, 1'b0}));

    // Single-word frame
    rom_mem[0] = {8'ha5, 1'b1}; len1 = 10'd0;
    s0 = strobes1; e0 = enlow1;
    pulse1();
    wait_done1("B", 40);
    tick(3);
    chk("B_done_cycle", done_at1, 7);
    chk("B_strobes", strobes1 - s0, 1);
    chk("B_en_low", enlow1 - e0, 0);
    chk("B_word", int'(last_w1), int'({8'ha5, 1'b1}));
    rom_mem[0] = {8'h3e, 1'b0};

    // Alternate WR timing on the second instance
    t2 = strobes2;
    start2 = 1'b1; tick(1); start2 = 1'b0;
    tick(40);
    chk("C_done_cycle", done_at2, 25);
    chk("C_strobes", strobes2 - t2, 4);

    // Reset during the low phase of word 20, then a clean restart
    len1 = 10'd50;
    pulse1();
    wait_wc1("D_word20", 20, 1'b1, 300);
    rst = 1'b1;
    #1;
    chk("D_rst_wr_n", int'(wr1), 1);
    chk("D_rst_cs_n", int'(cs1), 1);
    chk("D_rst_busy", int'(busy1), 0);
    chk("D_rst_word_cnt", int'(wc1), 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    s0 = strobes1; y0 = syncs1;
    pulse1();
    chk("D_restart_sync", int'(sync1), 1);
    wait_done1("D", 400);
    tick(3);
    chk("D_done_cycle", done_at1, 307);
    chk("D_strobes", strobes1 - s0, 51);
    chk("D_syncs", syncs1 - y0, 1);
    chk("D_first_word", int'(first_w1), int'({8'h3e, 1'b0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
